// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes, opcodes,
// datapath select encodings and the packed control vector.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_EXEC_I   = 4'd11,
    S_WB_I     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ASRCB_REGB    = 2'b00;
  localparam logic [1:0] ASRCB_FOUR    = 2'b01;
  localparam logic [1:0] ASRCB_IMM     = 2'b10;
  localparam logic [1:0] ASRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // States whose exit completes an instruction.
  function automatic logic is_retire_state(input logic [3:0] st);
    return (st == S_WB_MEM) || (st == S_MEM_WR) || (st == S_WB_R) ||
           (st == S_BRANCH) || (st == S_JUMP)   || (st == S_WB_I);
  endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// Pure state -> control-vector decoder; unknown encodings decode to all-zero.
module mc_ctrl_out
  import mc_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = ASRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
      end
      // Speculatively form the branch target into ALUOut.
      S_DECODE: begin
        ctrl.alu_src_b = ASRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ASRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_WB_I: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control FSM (Moore): state register, opcode-driven
// next-state logic, retired-instruction counter and illegal-opcode flag.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             illegal_q, illegal_d;
  logic             dec_illegal;
  ctrl_t            ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RST;
      instr_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    dec_illegal = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_EXEC_I;
          default:      dec_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_WB_MEM;
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      // Reset, retiring states and unused encodings all return to fetch.
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (is_retire_state(state_q))
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    illegal_d = dec_illegal | (ILLEGAL_STICKY & illegal_q);
  end

  mc_ctrl_out u_out (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign state       = state_q;
  assign instr_cnt   = instr_cnt_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes per-cycle expected state and
// controls; a negedge monitor pops and compares. Narrow counter to hit wrap.
module tb_mc_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          RegDst, MemtoReg, RegWrite, ALUSrcA, illegal;
  logic [1:0]    PCSource, ALUSrcB, ALUOp;
  logic [3:0]    state;
  logic [CW-1:0] instr_cnt;

  mc_ctrl #(.CNT_W(CW), .ILLEGAL_STICKY(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .state(state), .instr_cnt(instr_cnt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    st;
    logic [15:0]   ctl;
    logic [CW-1:0] cnt;
    logic          ill;
    string         nm;
  } exp_t;

  exp_t          expq[$];
  exp_t          e;
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_ill = 1'b0;
  bit            done = 1'b0;
  logic [15:0]   act_ctl;

  // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,
  //  RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp}
  function automatic logic [15:0] ctl_tab(input logic [3:0] st);
    case (st)
      4'd1:    return 16'b1_0_00_0_1_0_1_0_0_0_0_01_00;
      4'd2:    return 16'b0_0_00_0_0_0_0_0_0_0_0_11_00;
      4'd3:    return 16'b0_0_00_0_0_0_0_0_0_0_1_10_00;
      4'd4:    return 16'b0_0_00_1_1_0_0_0_0_0_0_00_00;
      4'd5:    return 16'b0_0_00_0_0_0_0_0_1_1_0_00_00;
      4'd6:    return 16'b0_0_00_1_0_1_0_0_0_0_0_00_00;
      4'd7:    return 16'b0_0_00_0_0_0_0_0_0_0_1_00_10;
      4'd8:    return 16'b0_0_00_0_0_0_0_1_0_1_0_00_00;
      4'd9:    return 16'b0_1_01_0_0_0_0_0_0_0_1_00_01;
      4'd10:   return 16'b1_0_10_0_0_0_0_0_0_0_0_00_00;
      4'd11:   return 16'b0_0_00_0_0_0_0_0_0_0_1_10_00;
      4'd12:   return 16'b0_0_00_0_0_0_0_0_0_1_0_00_00;
      default: return 16'b0;
    endcase
  endfunction

  task automatic push_exp(input logic [3:0] st, input string nm);
    exp_t x;
    x.st = st; x.ctl = ctl_tab(st); x.cnt = exp_cnt; x.ill = exp_ill; x.nm = nm;
    expq.push_back(x);
  endtask

  task automatic step(input logic [3:0] st, input string nm);
    @(posedge clk); #1;
    push_exp(st, nm);
  endtask

  // seq holds the post-FETCH states (nibble 0 first); ends with a FETCH check.
  task automatic instr(input logic [5:0] op, input logic [15:0] seq, input int n,
                       input bit retire, input bit bad, input string nm);
    opcode = op;
    for (int i = 0; i < n; i++) begin
      step(seq[i*4 +: 4], nm);
      if (i >= 2) opcode = 6'b111111;  // past MEM_ADDR the opcode must be ignored
    end
    if (retire) exp_cnt = exp_cnt + 1'b1;
    if (bad) exp_ill = 1'b1;
    step(4'd1, nm);
  endtask

  always @(negedge clk) begin
    act_ctl = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp};
    checks += 2;
    if (PCWrite && PCWriteCond) begin
      failures++; $display("FAIL pc_excl t=%0t both PC writes high, required exclusive", $time);
    end
    if (MemRead && MemWrite) begin
      failures++; $display("FAIL mem_excl t=%0t both mem strobes high, required exclusive", $time);
    end
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks += 4;
      if (state !== e.st) begin
        failures++; $display("FAIL %s state got %0d want %0d t=%0t", e.nm, state, e.st, $time);
      end
      if (act_ctl !== e.ctl) begin
        failures++; $display("FAIL %s ctrl got %b want %b t=%0t", e.nm, act_ctl, e.ctl, $time);
      end
      if (instr_cnt !== e.cnt) begin
        failures++; $display("FAIL %s instr_cnt got %0d want %0d t=%0t", e.nm, instr_cnt, e.cnt, $time);
      end
      if (illegal !== e.ill) begin
        failures++; $display("FAIL %s illegal got %b want %b t=%0t", e.nm, illegal, e.ill, $time);
      end
    end else if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) step(4'd0, "reset");
    rst = 1'b1;
    step(4'd1, "first_fetch");
    instr(6'b100011, 16'h5432, 4, 1'b1, 1'b0, "lw");
    instr(6'b101011, 16'h0632, 3, 1'b1, 1'b0, "sw");
    instr(6'b000000, 16'h0872, 3, 1'b1, 1'b0, "rtype");
    instr(6'b000010, 16'h00A2, 2, 1'b1, 1'b0, "j");
    instr(6'b000100, 16'h0092, 2, 1'b1, 1'b0, "beq");
    instr(6'b001000, 16'h0CB2, 3, 1'b1, 1'b0, "addi");
    instr(6'b111111, 16'h0002, 1, 1'b0, 1'b1, "illegal");
    instr(6'b001000, 16'h0CB2, 3, 1'b1, 1'b0, "addi2");
    instr(6'b000000, 16'h0872, 3, 1'b1, 1'b0, "rtype2");
    instr(6'b000010, 16'h00A2, 2, 1'b1, 1'b0, "j_wrap");
    // Abort a store in MEM_WR with an asynchronous reset mid-cycle.
    opcode = 6'b101011;
    step(4'd2, "sw_abort");
    step(4'd3, "sw_abort");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
    push_exp(4'd0, "reset_mid_memwr");
    step(4'd0, "reset_hold");
    rst = 1'b1;
    step(4'd1, "refetch");
    done = 1'b1;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle MIPS main control FSM. It drives the control side of the PC register interface (PCWrite, PCWriteCond, PCSource) and all datapath enables and selects for memory, instruction register, register file and ALU. It takes the IR opcode and steps through fetch, decode, execute, memory and writeback states. It also counts retired instructions for debug and verification.

Parameters:
CNT_W, 32, width of retired-instruction counter
ILLEGAL_STICKY, 1, 1 = illegal flag held until reset; 0 = one-cycle pulse

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
PCWrite  out  1  unconditional PC update
PCWriteCond  out  1  PC update to ALUOut when ALU zero=1
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
IorD  out  1  0 memory address = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  load IR from memory data
RegDst  out  1  0 rt, 1 rd
MemtoReg  out  1  0 ALUOut, 1 MDR
RegWrite  out  1  register file write
ALUSrcA  out  1  0 PC, 1 reg A
ALUSrcB  out  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
ALUOp  out  2  00 add, 01 sub, 10 per funct
state  out  4  current state encoding (debug)
instr_cnt  out  CNT_W  retired-instruction count
illegal  out  1  unsupported opcode decoded

Behaviour:
- Moore FSM. All control outputs decode combinationally from the state register only. Opcode affects only the next-state logic.
- Reset (rst=0, async): state=S_RST(0), instr_cnt=0, illegal=0. Every control output is 0 in S_RST. The first clock after rst deasserts goes to FETCH.
- Reset asserted mid-instruction aborts it immediately. No partial writes are allowed after the reset edge.
- States and outputs (unlisted outputs are 0):
  - FETCH(1): MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite, PCSource=00. Next: DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next by opcode:
    - 100011 or 101011 -> MEM_ADDR
    - 000000 -> EXEC_R
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> EXEC_I
    - anything else -> FETCH, with illegal set
  - MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEM_RD if lw, MEM_WR if sw.
  - MEM_RD(4): MemRead, IorD=1. Next: WB_MEM.
  - WB_MEM(5): RegWrite, MemtoReg=1, RegDst=0. Next: FETCH.
  - MEM_WR(6): MemWrite, IorD=1. Next: FETCH.
  - EXEC_R(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: WB_R.
  - WB_R(8): RegWrite, RegDst=1, MemtoReg=0. Next: FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. Next: FETCH.
  - JUMP(10): PCWrite, PCSource=10. Next: FETCH.
  - EXEC_I(11): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: WB_I.
  - WB_I(12): RegWrite, RegDst=0, MemtoReg=0. Next: FETCH.
  - Encodings 13-15: all outputs 0, next FETCH (recovery).
- Invariants: PCWrite and PCWriteCond are never both 1. MemRead and MemWrite are never both 1.
- Per-instruction cycle counts: lw 5; sw, R-type and addi 4; beq and j 3.
- instr_cnt increments by 1 on the clock edge that leaves WB_MEM, MEM_WR, WB_R, BRANCH, JUMP or WB_I. It wraps modulo 2^CNT_W. Illegal opcodes are not counted.
- illegal with ILLEGAL_STICKY=1: set on the edge leaving DECODE with an unsupported opcode; cleared only by reset.
- illegal with ILLEGAL_STICKY=0: high for exactly the one cycle following that edge.
- opcode is sampled in DECODE and MEM_ADDR only. It is ignored in all other states.

Decomposition:
- Shared package mc_pkg holds:
  - state localparams S_RST..S_WB_I
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - PCSource, ALUSrcB and ALUOp encodings, also used by the PC and ALU-control blocks
- One natural sub-module: mc_ctrl_out, a pure state -> control-vector decoder that can be reused in assertions.

Test Plan:
- rst=0 for 3 cycles, then release -> all controls 0 while rst=0; state 0 -> 1 -> 2 on the next edges.
- lw (opcode 100011) -> states 1,2,3,4,5,1. MemRead=1 in 1 and 4; IorD=1 in 4; RegWrite=1 with MemtoReg=1 in 5; instr_cnt 0 -> 1 leaving state 5.
- beq (000100) -> states 1,2,9,1. In 9: PCWriteCond=1, PCSource=01, ALUOp=01, PCWrite=0.
- j (000010) after R-type (000000) -> R sequence 1,2,7,8,1, then 1,2,10,1. In 10: PCWrite=1, PCSource=10. instr_cnt advances by 2.
- opcode 111111 -> DECODE goes straight to FETCH; illegal=1 (sticky); instr_cnt unchanged; RegWrite and MemWrite never asserted.
- rst pulled low during MEM_WR (state 6) -> MemWrite drops in the same cycle as the reset edge; state=0 and instr_cnt=0 immediately.
